// File: rtl/dio_download_bridge.sv
// Packs the 8-bit hps_io download stream into 16-bit SDRAM words written through the download slot.
// Optional `DIO_CHECKSUM_EN adds a running 16-bit sum of written words on dio_checksum.
`timescale 1ns/1ps
module dio_download_bridge #(
    parameter logic [20:0] ROM_BASE = 21'h000000,
    parameter logic [20:0] INT_BASE = 21'h080000,
    parameter logic [20:0] EXT_BASE = 21'h100000,
    parameter int unsigned DS_BYTES = 819200,
    parameter int unsigned SS_BYTES = 409600
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        dio_slot,
    output logic        mem_cycle,
    output logic [20:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_we,
    input  logic [1:0]  disk_eject,
    output logic [1:0]  dsk_ins,
    output logic [1:0]  dsk_ds,
    output logic [15:0] dio_checksum
);

    typedef enum logic [1:0] {StIdle, StPend, StArmed, StWrite} state_e;

    localparam logic [24:0] DsCnt = 25'(DS_BYTES);
    localparam logic [24:0] SsCnt = 25'(SS_BYTES);

    state_e      state_q, state_d;
    logic        dl_q;
    logic [7:0]  index_q, index_d;
    logic        half_q, half_d;
    logic [7:0]  hi_q, hi_d;
    logic [20:0] hi_addr_q, hi_addr_d;
    logic [24:0] cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic [20:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  ins_q, ins_d;
    logic [1:0]  ds_q, ds_d;

    logic        dl_start, dl_end, idx_ok, accept, finishing, size_ds, size_ss, write_done;
    logic [20:0] base_sel, word_addr;
    logic        unused_addr;

    assign unused_addr = ^ioctl_addr[24:22];

    always_comb begin
        case (ioctl_index)
            8'd1:    base_sel = INT_BASE;
            8'd2:    base_sel = EXT_BASE;
            default: base_sel = ROM_BASE;
        endcase
    end

    assign idx_ok     = ioctl_index < 8'd3;
    assign word_addr  = ioctl_addr[21:1] + base_sel;
    assign dl_start   = ioctl_download & ~dl_q;
    assign dl_end     = dl_q & ~ioctl_download;
    assign ioctl_wait = state_q != StIdle;
    assign accept     = ioctl_download & ioctl_wr & idx_ok & ~ioctl_wait;
    // Flush/flag latch waits for any in-flight word to retire first.
    assign finishing  = (dl_end | flush_q) & (state_q == StIdle);
    assign size_ds    = cnt_q == DsCnt;
    assign size_ss    = cnt_q == SsCnt;
    assign write_done = (state_q == StWrite) & ~dio_slot;

    assign mem_cycle = dio_slot & (ioctl_download | flush_q);
    // ARMED already saw the slot low, so asserting here covers the slot from its first cycle.
    assign mem_we    = mem_cycle & ((state_q == StArmed) | (state_q == StWrite));
    assign mem_addr  = addr_q;
    assign mem_data  = data_q;
    assign dsk_ins   = ins_q;
    assign dsk_ds    = ds_q;

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        half_d    = half_q;
        hi_d      = hi_q;
        hi_addr_d = hi_addr_q;
        cnt_d     = cnt_q;
        flush_d   = flush_q;
        addr_d    = addr_q;
        data_d    = data_q;
        ins_d     = ins_q;
        ds_d      = ds_q;

        if (ioctl_download) index_d = ioctl_index;
        if (dl_start) begin
            cnt_d  = '0;
            half_d = 1'b0;
        end

        case (state_q)
            StPend:  if (!dio_slot) state_d = StArmed;
            StArmed: if (dio_slot) state_d = StWrite;
            StWrite: if (!dio_slot) state_d = StIdle;
            default: ;
        endcase

        if (accept) begin
            cnt_d = cnt_d + 25'd1;
            if (!ioctl_addr[0]) begin
                hi_d      = ioctl_dout;
                hi_addr_d = word_addr;
                half_d    = 1'b1;
            end else begin
                data_d  = {hi_q, ioctl_dout};
                addr_d  = word_addr;
                half_d  = 1'b0;
                state_d = StPend;
            end
        end

        if (dl_end) flush_d = 1'b1;
        if (finishing) begin
            if (half_q) begin
                data_d  = {hi_q, 8'h00};
                addr_d  = hi_addr_q;
                half_d  = 1'b0;
                state_d = StPend;
                flush_d = 1'b1;
            end else begin
                flush_d = 1'b0;
                if (index_q == 8'd1) begin
                    ins_d[0] = size_ds | size_ss;
                    ds_d[0]  = size_ds;
                end else if (index_q == 8'd2) begin
                    ins_d[1] = size_ds | size_ss;
                    ds_d[1]  = size_ds;
                end
            end
        end

        ins_d = ins_d & ~disk_eject;
        ds_d  = ds_d & ~disk_eject;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            dl_q      <= 1'b0;
            index_q   <= '0;
            half_q    <= 1'b0;
            hi_q      <= '0;
            hi_addr_q <= '0;
            cnt_q     <= '0;
            flush_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            ins_q     <= '0;
            ds_q      <= '0;
        end else begin
            state_q   <= state_d;
            dl_q      <= ioctl_download;
            index_q   <= index_d;
            half_q    <= half_d;
            hi_q      <= hi_d;
            hi_addr_q <= hi_addr_d;
            cnt_q     <= cnt_d;
            flush_q   <= flush_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ins_q     <= ins_d;
            ds_q      <= ds_d;
        end
    end

`ifdef DIO_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (dl_start) csum_d = '0;
        else if (write_done) csum_d = csum_q + data_q;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign dio_checksum = csum_q;
`else
    logic unused_write_done;
    assign unused_write_done = write_done;
    assign dio_checksum      = 16'h0000;
`endif

endmodule

// File: tb/tb_dio_download_bridge.sv
// Bench for dio_download_bridge: vector table of downloads plus hand sequences for eject,
// address wrap and reset mid-write; written words are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_dio_download_bridge;

    localparam int unsigned DsB     = 64;
    localparam int unsigned SsB     = 32;
    localparam int          SlotLen = 8;
    localparam logic [20:0] RomB    = 21'h000000;
    localparam logic [20:0] IntB    = 21'h080000;
    localparam logic [20:0] ExtB    = 21'h100000;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        dio_slot;
    logic        mem_cycle;
    logic [20:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic [1:0]  disk_eject;
    logic [1:0]  dsk_ins;
    logic [1:0]  dsk_ds;
    logic [15:0] dio_checksum;

    dio_download_bridge #(
        .ROM_BASE(RomB),
        .INT_BASE(IntB),
        .EXT_BASE(ExtB),
        .DS_BYTES(DsB),
        .SS_BYTES(SsB)
    ) u_dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait),
        .dio_slot(dio_slot),
        .mem_cycle(mem_cycle),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_we(mem_we),
        .disk_eject(disk_eject),
        .dsk_ins(dsk_ins),
        .dsk_ds(dsk_ds),
        .dio_checksum(dio_checksum)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0]  idx;
        int          nbytes;
        logic [31:0] head;
        logic        exp_ins;
        logic        exp_ds;
        logic [20:0] exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic [20:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         sb[$];
    vec_t        vecs[7];
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  cur_idx;
    logic [7:0]  m_hi;
    logic        m_half;
    logic [20:0] m_hi_addr;
    logic [15:0] m_sum;
    logic [1:0]  m_ins, m_ds;
    logic        slot_run, slot_force;
    int          slot_cnt;
    logic        we_prev, fell_q;
    int          we_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] base_of(input logic [7:0] idx);
        case (idx)
            8'd1:    return IntB;
            8'd2:    return ExtB;
            default: return RomB;
        endcase
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] head, input int i);
        if (i < 4) return head[31-8*i -: 8];
        return 8'(i) ^ 8'h5A;
    endfunction

    function automatic logic [15:0] exp_sum();
`ifdef DIO_CHECKSUM_EN
        return m_sum;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_free(input string name);
        int guard = 0;
        while (ioctl_wait && guard < 64) begin
            step();
            guard++;
        end
        check(name, 32'(ioctl_wait), 32'd0);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        cur_idx        = idx;
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        m_sum          = 16'h0000;
        m_half         = 1'b0;
        step();
    endtask

    task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
        logic [20:0] wa;
        wait_free("wait_before_strobe");
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        step();
        ioctl_wr   = 1'b0;
        wa = base_of(cur_idx) + addr[21:1];
        if (cur_idx <= 8'd2) begin
            if (!addr[0]) begin
                m_hi      = data;
                m_half    = 1'b1;
                m_hi_addr = wa;
            end else begin
                sb.push_back('{addr: wa, data: {m_hi, data}});
                m_sum  = m_sum + {m_hi, data};
                m_half = 1'b0;
            end
        end
    endtask

    task automatic set_flags(input logic ins, input logic ds);
        if (cur_idx == 8'd1) begin
            m_ins[0] = ins;
            m_ds[0]  = ds;
        end else if (cur_idx == 8'd2) begin
            m_ins[1] = ins;
            m_ds[1]  = ds;
        end
    endtask

    task automatic check_end();
        check("dsk_ins", 32'(dsk_ins), 32'(m_ins));
        check("dsk_ds", 32'(dsk_ds), 32'(m_ds));
        check("checksum", 32'(dio_checksum), 32'(exp_sum()));
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic end_dl(input logic ins, input logic ds);
        logic flush;
        int   guard = 0;
        wait_free("wait_before_end");
        flush          = m_half;
        ioctl_download = 1'b0;
        if (flush) begin
            sb.push_back('{addr: m_hi_addr, data: {m_hi, 8'h00}});
            m_sum  = m_sum + {m_hi, 8'h00};
            m_half = 1'b0;
        end
        set_flags(ins, ds);
        step();
        if (flush) begin
            check("wait_during_flush", 32'(ioctl_wait), 32'd1);
            while (ioctl_wait && guard < 64) begin
                step();
                guard++;
            end
            check("flush_done", 32'(ioctl_wait), 32'd0);
            step();
        end
        check_end();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wait"}, 32'(ioctl_wait), 32'd0);
        check({tag, "_cycle"}, 32'(mem_cycle), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_data"}, 32'(mem_data), 32'd0);
        check({tag, "_ins"}, 32'(dsk_ins), 32'd0);
        check({tag, "_ds"}, 32'(dsk_ds), 32'd0);
        check({tag, "_csum"}, 32'(dio_checksum), 32'd0);
    endtask

    initial begin
        reset = 1'b1; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; dio_slot = 1'b0; disk_eject = '0;
        slot_run = 1'b1; slot_force = 1'b0; slot_cnt = 0;
        we_prev = 1'b0; fell_q = 1'b0; we_len = 0;
        cur_idx = '0; m_hi = '0; m_half = 1'b0; m_hi_addr = '0; m_sum = '0;
        m_ins = '0; m_ds = '0;

        vecs[0] = '{8'd0, 2,   32'h1234_0000, 1'b0, 1'b0, 21'h000000, 16'h1234};
        vecs[1] = '{8'd1, DsB, 32'h0000_0000, 1'b1, 1'b1, IntB + 21'd31, 16'h6465};
        vecs[2] = '{8'd1, SsB, 32'h0000_0000, 1'b1, 1'b0, IntB + 21'd15, 16'h4445};
        vecs[3] = '{8'd1, 10,  32'h0000_0000, 1'b0, 1'b0, IntB + 21'd4,  16'h5253};
        vecs[4] = '{8'd2, 3,   32'hAABB_CC00, 1'b0, 1'b0, 21'h100001, 16'hCC00};
        vecs[5] = '{8'd0, 4,   32'hFFFF_0002, 1'b0, 1'b0, 21'h000001, 16'h0002};
        vecs[6] = '{8'd5, 6,   32'h1122_3344, 1'b0, 1'b0, 21'h000001, 16'h0002};

        fork
            forever begin
                @(posedge clk_sys);
                #1;
                if (slot_run) begin
                    if (slot_cnt == SlotLen - 1) begin
                        slot_cnt = 0;
                        dio_slot = ~dio_slot;
                    end else begin
                        slot_cnt++;
                    end
                end else begin
                    dio_slot = slot_force;
                    slot_cnt = 0;
                end
            end
            forever begin
                wr_t w;
                @(negedge clk_sys);
                if (fell_q) check("wait_clear_after_slot", 32'(ioctl_wait), 32'd0);
                fell_q = 1'b0;
                if (mem_we) check("we_inside_slot", 32'(dio_slot), 32'd1);
                if (mem_we && !we_prev) begin
                    check("write_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        w = sb.pop_front();
                        check("wr_addr", 32'(mem_addr), 32'(w.addr));
                        check("wr_data", 32'(mem_data), 32'(w.data));
                    end
                end
                if (mem_we) we_len++;
                if (!mem_we && we_prev) begin
                    if (slot_run) check("we_full_slot", 32'(we_len), 32'(SlotLen));
                    we_len = 0;
                    fell_q = 1'b1;
                end
                we_prev = mem_we;
            end
            begin
                #1ms;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

        for (int v = 0; v < 7; v++) begin
            start_dl(vecs[v].idx);
            for (int i = 0; i < vecs[v].nbytes; i++) send_byte(25'(i), byte_at(vecs[v].head, i));
            if (vecs[v].idx > 8'd2) check("invalid_idx_no_wait", 32'(ioctl_wait), 32'd0);
            end_dl(vecs[v].exp_ins, vecs[v].exp_ds);
            check("last_addr", 32'(mem_addr), 32'(vecs[v].exp_addr));
            check("last_data", 32'(mem_data), 32'(vecs[v].exp_data));
`ifdef DIO_CHECKSUM_EN
            if (v == 5) check("checksum_wrap", 32'(dio_checksum), 32'h0001);
`endif
        end

        // Stand-alone eject of the internal drive.
        start_dl(8'd1);
        for (int i = 0; i < SsB; i++) send_byte(25'(i), byte_at(32'h0, i));
        end_dl(1'b1, 1'b0);
        disk_eject = 2'b01;
        step();
        disk_eject = 2'b00;
        m_ins[0] = 1'b0;
        m_ds[0]  = 1'b0;
        check("eject_int_ins", 32'(dsk_ins), 32'(m_ins));

        // External image, then eject coinciding with the next end latch.
        start_dl(8'd2);
        for (int i = 0; i < DsB; i++) send_byte(25'(i), byte_at(32'h0, i));
        end_dl(1'b1, 1'b1);
        start_dl(8'd2);
        for (int i = 0; i < DsB; i++) send_byte(25'(i), byte_at(32'h0, i));
        wait_free("wait_before_eject_end");
        ioctl_download = 1'b0;
        disk_eject     = 2'b10;
        step();
        disk_eject = 2'b00;
        m_ins[1] = 1'b0;
        m_ds[1]  = 1'b0;
        check_end();

        // Offset past the top of the word space wraps to 0.
        start_dl(8'd2);
        send_byte(25'h200000, 8'h5A);
        send_byte(25'h200001, 8'hA5);
        end_dl(1'b0, 1'b0);
        check("wrap_addr", 32'(mem_addr), 32'd0);
        check("wrap_data", 32'(mem_data), 32'h5AA5);

        // Reset while ARMED: load flags first so reset has something to clear.
        start_dl(8'd1);
        for (int i = 0; i < DsB; i++) send_byte(25'(i), byte_at(32'h0, i));
        end_dl(1'b1, 1'b1);
        slot_run   = 1'b0;
        slot_force = 1'b0;
        step();
        step();
        start_dl(8'd0);
        send_byte(25'd0, 8'h12);
        send_byte(25'd1, 8'h34);
        step();
        step();
        check("armed_wait", 32'(ioctl_wait), 32'd1);
        reset          = 1'b1;
        ioctl_download = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        slot_force = 1'b1;
        step();
        step();
        check("reset_no_we", 32'(mem_we), 32'd0);
        reset = 1'b0;
        sb.delete();
        m_ins = '0;
        m_ds  = '0;
        slot_force = 1'b0;
        step();
        step();
        slot_run = 1'b1;

        // Recovery after reset.
        start_dl(8'd0);
        send_byte(25'd2, 8'h9C);
        send_byte(25'd3, 8'h3E);
        end_dl(1'b0, 1'b0);
        check("post_reset_addr", 32'(mem_addr), 32'd1);
        check("post_reset_data", 32'(mem_data), 32'h9C3E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
